// File: rtl/hilo_pkg.sv
// Shared op codes, FSM state encoding and op-class helpers for the HI/LO multiply/divide unit.
package hilo_pkg;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
  localparam logic [2:0] OP_NOP7  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  function automatic logic is_muldiv(input logic [2:0] op);
    return (op >= OP_MULT) && (op <= OP_DIVU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// One combinational iteration on {acc,q}: shift-add multiply (right shift) or restoring
// divide (left shift). Operands are unsigned magnitudes; signs are handled by the caller.
module muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_shl;
  logic [WIDTH:0] w_diff;
  logic           w_ge;

  always_comb begin
    w_sum  = {1'b0, i_acc} + (i_q[0] ? {1'b0, i_b} : '0);
    w_shl  = {i_acc, i_q[WIDTH-1]};
    w_diff = w_shl - {1'b0, i_b};
    w_ge   = (w_shl >= {1'b0, i_b});
    if (i_is_div) begin
      o_acc = w_ge ? w_diff[WIDTH-1:0] : w_shl[WIDTH-1:0];
      o_q   = {i_q[WIDTH-2:0], w_ge};
    end else begin
      // Carry out of the add becomes the new top bit; the LSB retires into q.
      o_acc = w_sum[WIDTH:1];
      o_q   = {w_sum[0], i_q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers, MTHI/MTLO writes and busy/done handshake.
// Optional divide-by-zero early exit and flag: define MULDIV_DIV0_DETECT_EN.
module hilo_muldiv_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] outHI,
  output logic [WIDTH-1:0] outLO,
  output logic [1:0]       o_dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc, r_q, r_b, r_hi, r_lo;
  logic             r_is_div, r_neg_lo, r_neg_hi, r_done;
  logic             w_accept, w_mt_hi, w_mt_lo, w_dz_skip, w_signed, w_div_op;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_core_acc, w_core_q, w_hi_fix, w_lo_fix;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;

  assign w_signed = is_signed_op(op);
  assign w_div_op = is_div(op);
  assign w_a_mag  = (w_signed && A[WIDTH-1]) ? (WIDTH'(0) - A) : A;
  assign w_b_mag  = (w_signed && B[WIDTH-1]) ? (WIDTH'(0) - B) : B;

`ifdef MULDIV_DIV0_DETECT_EN
  logic r_dz, r_div0;
  assign w_dz_skip = w_div_op && (B == '0);
  assign div0      = r_div0;
`else
  assign w_dz_skip = 1'b0;
  assign div0      = 1'b0;
`endif

  // Handshake: start is only looked at while busy=0; a multi-cycle op is accepted on that
  // edge and done pulses for one cycle with HI/LO already updated and busy back at 0.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_mt_hi     = 1'b0;
    w_mt_lo     = 1'b0;
    unique case (r_state)
      S_IDLE: if (start) begin
        if (is_muldiv(op)) begin
          w_accept    = 1'b1;
          w_state_nxt = w_dz_skip ? S_FIX : S_CALC;
        end else if (op == OP_MTHI) begin
          w_mt_hi = 1'b1;
        end else if (op == OP_MTLO) begin
          w_mt_lo = 1'b1;
        end
      end
      S_CALC:  if (r_cnt == LAST) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .i_is_div (r_is_div),
    .i_acc    (r_acc),
    .i_q      (r_q),
    .i_b      (r_b),
    .o_acc    (w_core_acc),
    .o_q      (w_core_q)
  );

  always_comb begin
    w_prod     = {r_acc, r_q};
    w_prod_fix = r_neg_lo ? ((2*WIDTH)'(0) - w_prod) : w_prod;
    if (r_is_div) begin
      w_hi_fix = r_neg_hi ? (WIDTH'(0) - r_acc) : r_acc;
      w_lo_fix = r_neg_lo ? (WIDTH'(0) - r_q) : r_q;
    end else begin
      w_hi_fix = w_prod_fix[2*WIDTH-1:WIDTH];
      w_lo_fix = w_prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_is_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_done   <= 1'b0;
`ifdef MULDIV_DIV0_DETECT_EN
      r_dz     <= 1'b0;
      r_div0   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef MULDIV_DIV0_DETECT_EN
      r_div0 <= 1'b0;
`endif
      if (w_mt_hi) r_hi <= A;
      if (w_mt_lo) r_lo <= A;
      if (w_accept) begin
        r_cnt    <= '0;
        r_acc    <= '0;
        r_is_div <= w_div_op;
        r_q      <= w_div_op ? w_a_mag : w_b_mag;
        r_b      <= w_div_op ? w_b_mag : w_a_mag;
        // A zero divisor keeps the quotient positive so LO comes out all ones.
        r_neg_lo <= w_signed && (A[WIDTH-1] ^ B[WIDTH-1]) && !(w_div_op && (B == '0));
        r_neg_hi <= w_signed && w_div_op && A[WIDTH-1];
`ifdef MULDIV_DIV0_DETECT_EN
        r_dz     <= w_dz_skip;
`endif
      end else if (r_state == S_CALC) begin
        r_acc <= w_core_acc;
        r_q   <= w_core_q;
        r_cnt <= r_cnt + 1'b1;
      end else if (r_state == S_FIX) begin
        r_done <= 1'b1;
`ifdef MULDIV_DIV0_DETECT_EN
        r_div0 <= r_dz;
        if (!r_dz) begin
          r_hi <= w_hi_fix;
          r_lo <= w_lo_fix;
        end
`else
        r_hi <= w_hi_fix;
        r_lo <= w_lo_fix;
`endif
      end
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign outHI       = r_hi;
  assign outLO       = r_lo;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed vector bench for hilo_muldiv_unit: table of mult/div ops plus hand-written
// sequences for MT* while busy, idle MT*, NOP starts and reset in the middle of a divide.
module tb_hilo_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, busy, done, div0;
  logic [2:0]   op;
  logic [W-1:0] A, B, outHI, outLO;
  logic [1:0]   dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .div0        (div0),
    .outHI       (outHI),
    .outLO       (outLO),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
    logic         dz;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op and count cycles from the accept edge until done is seen (bounded).
  task automatic run_op(input logic [2:0] op_i, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                        output int lat, output logic dz_seen, output logic busy_in_done);
    @(negedge clk);
    start = 1'b1; op = op_i; A = a_i; B = b_i;
    @(posedge clk); #1;
    start = 1'b0; op = 3'b000;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    dz_seen      = div0;
    busy_in_done = busy;
  endtask

  initial begin
    int   lat;
    logic dz, bz;
    int   cyc;
    logic seen;

    vecs[0] = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, 1'b0};
    vecs[1] = '{3'b001, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33, 1'b0};
    vecs[2] = '{3'b011, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b0};
    vecs[3] = '{3'b100, 32'd100,       32'd7,         32'd2,         32'd14,        33, 1'b0};
    vecs[4] = '{3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33, 1'b0};
    vecs[5] = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 33, 1'b0};
    vecs[6] = '{3'b011, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33, 1'b0};
    vecs[7] = '{3'b010, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 33, 1'b0};
`ifdef MULDIV_DIV0_DETECT_EN
    vecs[8] = '{3'b100, 32'd5,         32'd0,         32'h0000_0001, 32'h2345_6780, 1,  1'b1};
    vecs[9] = '{3'b011, 32'hFFFF_FFFB, 32'd0,         32'h0000_0001, 32'h2345_6780, 1,  1'b1};
`else
    vecs[8] = '{3'b100, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 33, 1'b0};
    vecs[9] = '{3'b011, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 33, 1'b0};
`endif

    reset = 1'b1; start = 1'b0; op = 3'b000; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hi", outHI, '0);
    check("reset_lo", outLO, '0);
    check("reset_busy", {31'd0, busy}, '0);
    check("reset_done", {31'd0, done}, '0);
    check("reset_div0", {31'd0, div0}, '0);
    check("reset_state", {30'd0, dbg_state}, '0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, dz, bz);
      check($sformatf("v%0d_hi", i), outHI, vecs[i].hi);
      check($sformatf("v%0d_lo", i), outLO, vecs[i].lo);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_div0", i), {31'd0, dz}, {31'd0, vecs[i].dz});
      check($sformatf("v%0d_busy_in_done", i), {31'd0, bz}, '0);
    end

    // done must be a single-cycle pulse.
    @(posedge clk); #1;
    check("done_pulse_width", {31'd0, done}, '0);
    check("div0_after_done", {31'd0, div0}, '0);

    // NOP starts change nothing.
    @(negedge clk); start = 1'b1; op = 3'b000; A = 32'hDEAD_BEEF;
    @(negedge clk); op = 3'b111;
    @(posedge clk); #1;
    start = 1'b0;
    check("nop_busy", {31'd0, busy}, '0);
    check("nop_hi", outHI, vecs[9].hi);
    check("nop_lo", outLO, vecs[9].lo);

    // MTHI while a MULT is running is ignored.
    @(negedge clk); start = 1'b1; op = 3'b001; A = 32'd3; B = 32'd5;
    @(posedge clk); #1; start = 1'b0; op = 3'b000;
    repeat (4) @(posedge clk);
    @(negedge clk); start = 1'b1; op = 3'b101; A = 32'h0000_1234;
    @(posedge clk); #1; start = 1'b0; op = 3'b000;
    check("busy_during_mult", {31'd0, busy}, 32'd1);
    cyc = 0;
    while (!done && cyc < 100) begin @(posedge clk); #1; cyc++; end
    check("mt_ignored_done_seen", {31'd0, done}, 32'd1);
    check("mt_ignored_hi", outHI, 32'd0);
    check("mt_ignored_lo", outLO, 32'd15);

    // Idle MTHI/MTLO: written next edge, no busy, no done.
    @(negedge clk); start = 1'b1; op = 3'b101; A = 32'h0000_1234;
    @(posedge clk); #1; start = 1'b0; op = 3'b000;
    check("mthi_hi", outHI, 32'h0000_1234);
    check("mthi_done", {31'd0, done}, '0);
    check("mthi_busy", {31'd0, busy}, '0);
    @(negedge clk); start = 1'b1; op = 3'b110; A = 32'h0000_ABCD;
    @(posedge clk); #1; start = 1'b0; op = 3'b000;
    check("mtlo_lo", outLO, 32'h0000_ABCD);
    check("mtlo_hi_kept", outHI, 32'h0000_1234);
    check("mtlo_done", {31'd0, done}, '0);

    // Reset ten cycles into a DIV abandons it.
    @(negedge clk); start = 1'b1; op = 3'b011; A = 32'd100; B = 32'd7;
    @(posedge clk); #1; start = 1'b0; op = 3'b000;
    repeat (9) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("midreset_hi", outHI, '0);
    check("midreset_lo", outLO, '0);
    check("midreset_busy", {31'd0, busy}, '0);
    check("midreset_state", {30'd0, dbg_state}, '0);
    @(negedge clk); reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check("midreset_no_done", {31'd0, seen}, '0);
    run_op(3'b010, 32'd2, 32'd3, lat, dz, bz);
    check("post_reset_lo", outLO, 32'd6);
    check("post_reset_hi", outHI, 32'd0);
    check("post_reset_latency", 32'(lat), 32'd33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
